// File: rtl/audiodac_pkg.sv
// Shared definitions for the DAC FIFO feeder: FSM state encoding and default sizing.
package audiodac_pkg;

  localparam int DW_DEF     = 16;
  localparam int TO_CYC_DEF = 255;
  localparam int TO_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the channel that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic ptr;

  always_comb begin
    gnt_idx = 1'b0;
    gnt     = 2'b00;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ptr;
      default: gnt_idx = 1'b0;
    endcase
    if (req != 2'b00) gnt = gnt_idx ? 2'b10 : 2'b01;
  end

  // The channel just granted loses the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       ptr <= 1'b0;
    else if (adv && req != 2'b00)  ptr <= ~gnt_idx;
  end

endmodule

// File: rtl/dac_fifo_feeder_arb.sv
// Shares one registered sample bus between two sources, each feeding its own DAC FIFO
// through a 4-phase rdy/ack handshake with a per-phase timeout.
module dac_fifo_feeder_arb
  import audiodac_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int TO_CYC = TO_CYC_DEF,
  parameter int TO_W   = TO_W_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] s0_dat_i,
  input  logic          s0_vld_i,
  output logic          s0_rdy_o,
  input  logic [DW-1:0] s1_dat_i,
  input  logic          s1_vld_i,
  output logic          s1_rdy_o,
  input  logic [1:0]    en_i,
  output logic [DW-1:0] fifo_dat_o,
  output logic          fifo_rdy0_o,
  input  logic          fifo_ack0_i,
  input  logic          fifo_full0_i,
  output logic          fifo_rdy1_o,
  input  logic          fifo_ack1_i,
  input  logic          fifo_full1_i,
  input  logic          err_clr_i,
  output logic [1:0]    err_o,
  output logic          busy_o,
  output logic          gnt_o
);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [DW-1:0]   dat_q, dat_d;
  logic [1:0]      rdy_q, rdy_d;
  logic [1:0]      err_q, err_d, err_set;
  logic            gnt_q, gnt_d;
  logic [1:0]      elig, arb_req, arb_gnt;
  logic            arb_idx, arb_adv;
  logic            ack_sel, tc;

  assign elig[0] = s0_vld_i & en_i[0] & ~fifo_full0_i;
  assign elig[1] = s1_vld_i & en_i[1] & ~fifo_full1_i;

  assign arb_req = (state_q == IDLE) ? elig : 2'b00;
  assign arb_adv = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (arb_req),
    .adv     (arb_adv),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Only the owning channel's ack matters; the other one is ignored.
  assign ack_sel = gnt_q ? fifo_ack1_i : fifo_ack0_i;
  assign tc      = (cnt_q == TO_W'(TO_CYC - 1));
  assign cnt_inc = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + TO_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    rdy_d    = rdy_q;
    gnt_d    = gnt_q;
    err_set  = 2'b00;
    s0_rdy_o = 1'b0;
    s1_rdy_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          s0_rdy_o = arb_gnt[0];
          s1_rdy_o = arb_gnt[1];
          dat_d    = arb_idx ? s1_dat_i : s0_dat_i;
          rdy_d    = arb_gnt;
          gnt_d    = arb_idx;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (ack_sel) begin
          rdy_d   = 2'b00;
          cnt_d   = '0;
          state_d = REL;
        end else if (tc) begin
          rdy_d            = 2'b00;
          err_set[gnt_q]   = 1'b1;
          state_d          = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REL: begin
        if (!ack_sel) begin
          state_d = IDLE;
        end else if (tc) begin
          err_set[gnt_q] = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        rdy_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // A timeout set beats a simultaneous clear on the same bit.
  assign err_d = (err_q & ~{2{err_clr_i}}) | err_set;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dat_q   <= '0;
      rdy_q   <= 2'b00;
      err_q   <= 2'b00;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
    end
  end

  assign fifo_dat_o  = dat_q;
  assign fifo_rdy0_o = rdy_q[0];
  assign fifo_rdy1_o = rdy_q[1];
  assign err_o       = err_q;
  assign gnt_o       = gnt_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dac_fifo_feeder_arb.sv
// Randomized bench for dac_fifo_feeder_arb checked every cycle against a transaction-level model.
module tb_dac_fifo_feeder_arb;

  localparam int DW     = 16;
  localparam int TO_CYC = 8;
  localparam int TO_W   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s0_dat, s1_dat, fifo_dat;
  logic          s0_vld, s1_vld, s0_rdy, s1_rdy;
  logic [1:0]    en, full, ack, err;
  logic          rdy0, rdy1, err_clr, busy, gnt;

  dac_fifo_feeder_arb #(.DW(DW), .TO_CYC(TO_CYC), .TO_W(TO_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s0_dat_i     (s0_dat),
    .s0_vld_i     (s0_vld),
    .s0_rdy_o     (s0_rdy),
    .s1_dat_i     (s1_dat),
    .s1_vld_i     (s1_vld),
    .s1_rdy_o     (s1_rdy),
    .en_i         (en),
    .fifo_dat_o   (fifo_dat),
    .fifo_rdy0_o  (rdy0),
    .fifo_ack0_i  (ack[0]),
    .fifo_full0_i (full[0]),
    .fifo_rdy1_o  (rdy1),
    .fifo_ack1_i  (ack[1]),
    .fifo_full1_i (full[1]),
    .err_clr_i    (err_clr),
    .err_o        (err),
    .busy_o       (busy),
    .gnt_o        (gnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: one transfer in flight at most, described by owner, phase and elapsed cycles.
  logic          m_busy, m_phase_hi, m_gnt, m_pref;
  int            m_ch, m_el;
  logic [DW-1:0] m_dat;
  logic [1:0]    m_rdy, m_err;

  // DAC responder behaviour per channel: 0 random, 1 ack=rdy, 2 ack one cycle late, 3 silent
  int         ack_mode [2];
  logic [1:0] prev_rdy;
  logic [1:0] obs_srdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_phase_hi = 0; m_gnt = 0; m_pref = 0;
    m_ch = 0; m_el = 0; m_dat = '0; m_rdy = 2'b00; m_err = 2'b00;
    prev_rdy = 2'b00;
  endtask

  // One clock: drive acks at negedge, check, advance model; returns at posedge+1.
  task automatic step();
    logic [1:0] e, exp_srdy, nerr, rv;
    logic       a;
    int         c;
    @(negedge clk);
    rv = {rdy1, rdy0};
    for (int n = 0; n < 2; n++) begin
      case (ack_mode[n])
        0:       ack[n] = 1'($urandom_range(0, 1));
        1:       ack[n] = rv[n];
        2:       ack[n] = prev_rdy[n];
        default: ack[n] = 1'b0;
      endcase
    end
    prev_rdy = rv;
    #1;
    chk("fifo_dat", 32'(fifo_dat), 32'(m_dat));
    chk("fifo_rdy", 32'({rdy1, rdy0}), 32'(m_rdy));
    chk("rdy_overlap", 32'(rdy0 & rdy1), 32'd0);
    chk("err", 32'(err), 32'(m_err));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("gnt", 32'(gnt), 32'(m_gnt));
    e = {s1_vld & en[1] & ~full[1], s0_vld & en[0] & ~full[0]};
    exp_srdy = 2'b00;
    c = 0;
    if (!m_busy && e != 2'b00) begin
      c = (e == 2'b11) ? int'(m_pref) : (e[0] ? 0 : 1);
      exp_srdy[c] = 1'b1;
    end
    chk("s_rdy", 32'({s1_rdy, s0_rdy}), 32'(exp_srdy));
    obs_srdy = {s1_rdy, s0_rdy};
    nerr = err_clr ? 2'b00 : m_err;
    if (!m_busy) begin
      if (e != 2'b00) begin
        m_busy = 1; m_ch = c; m_dat = (c == 1) ? s1_dat : s0_dat;
        m_rdy = 2'b00; m_rdy[c] = 1'b1; m_gnt = (c == 1); m_pref = (c == 0);
        m_phase_hi = 1; m_el = 0;
      end
    end else begin
      a = ack[m_ch];
      if (m_phase_hi) begin
        if (a) begin m_rdy = 2'b00; m_phase_hi = 0; m_el = 0; end
        else if (m_el == TO_CYC - 1) begin m_rdy = 2'b00; nerr[m_ch] = 1'b1; m_busy = 0; end
        else m_el++;
      end else begin
        if (!a) m_busy = 0;
        else if (m_el == TO_CYC - 1) begin nerr[m_ch] = 1'b1; m_busy = 0; end
        else m_el++;
      end
    end
    m_err = nerr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s0_vld = 0; s1_vld = 0;
    ack_mode[0] = 1; ack_mode[1] = 1;
    for (int i = 0; i < 40 && m_busy; i++) step();
    chk("drain_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt0, cnt1, hi, gs, first;
    rst = 1; s0_dat = '0; s1_dat = '0; s0_vld = 0; s1_vld = 0;
    en = 2'b00; full = 2'b00; ack = 2'b00; err_clr = 0;
    ack_mode[0] = 1; ack_mode[1] = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dat", 32'(fifo_dat), 32'd0);
    chk("rst_rdy", 32'({rdy1, rdy0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Enables off: nothing may be granted.
    s0_vld = 1; s1_vld = 1; s0_dat = 16'hAAAA; s1_dat = 16'h5555;
    cnt0 = 0;
    repeat (10) begin step(); if (obs_srdy != 0 || busy) cnt0++; end
    chk("t6_no_activity", 32'(cnt0), 32'd0);

    // Both eligible, immediate acks: strict alternation from ch0, 3 cycles per sample.
    en = 2'b11; gs = 0; cnt0 = 0;
    for (int i = 0; i < 12; i++) begin
      s0_dat = 16'($urandom); s1_dat = 16'($urandom);
      step();
      if (obs_srdy != 0) begin cnt0++; gs = (gs << 1) | int'(obs_srdy[1]); end
    end
    chk("t2_grant_count", 32'(cnt0), 32'd4);
    chk("t2_grant_seq", 32'(gs), 32'b0101);
    drain();

    // Single ch0 sample with a one-cycle-late ack.
    en = 2'b01; ack_mode[0] = 2; s0_vld = 1; s0_dat = 16'h1234; s1_vld = 0;
    step();
    chk("t1_grant", 32'(obs_srdy), 32'b01);
    chk("t1_dat", 32'(fifo_dat), 32'h1234);
    chk("t1_rdy0", 32'(rdy0), 32'd1);
    s0_vld = 0; cnt0 = 0;
    for (int i = 0; i < 20 && m_busy; i++) begin step(); if (obs_srdy != 0) cnt0++; end
    chk("t1_extra_pulses", 32'(cnt0), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    drain();

    // ch0 FIFO full: only ch1 served; once it frees, ch0 is next.
    en = 2'b11; full = 2'b01; s0_vld = 1; s1_vld = 1; cnt0 = 0; cnt1 = 0;
    repeat (9) begin step(); if (obs_srdy[0]) cnt0++; if (obs_srdy[1]) cnt1++; end
    chk("t3_ch0_blocked", 32'(cnt0), 32'd0);
    chk("t3_ch1_grants", 32'(cnt1), 32'd3);
    full = 2'b00; first = -1;
    for (int i = 0; i < 10 && first < 0; i++) begin
      step();
      if (obs_srdy != 0) first = int'(obs_srdy[1]);
    end
    chk("t3_next_ch0", 32'(first), 32'd0);
    drain();

    // Silent DAC1: rdy1 held for TO_CYC cycles, then err[1].
    en = 2'b10; s1_vld = 1; s1_dat = 16'hBEEF; ack_mode[1] = 3;
    step();
    chk("t4_grant", 32'(obs_srdy), 32'b10);
    s1_vld = 0; hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (!rdy1) break;
      hi++;
      step();
    end
    chk("t4_rdy1_cycles", 32'(hi), 32'd8);
    chk("t4_err", 32'(err), 32'b10);
    chk("t4_idle", 32'(busy), 32'd0);
    err_clr = 1; step(); err_clr = 0;
    chk("t4_err_clr", 32'(err), 32'd0);

    // Async reset in the middle of REQ.
    en = 2'b01; s0_vld = 1; s0_dat = 16'hC0DE; ack_mode[0] = 3;
    step(); s0_vld = 0; step();
    chk("t5_pre_rdy0", 32'(rdy0), 32'd1);
    #2 rst = 1;
    #1;
    chk("t5_rst_rdy0", 32'(rdy0), 32'd0);
    chk("t5_rst_dat", 32'(fifo_dat), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_srdy", 32'({s1_rdy, s0_rdy}), 32'd0);
    model_reset();
    en = 2'b00; ack = 2'b00;
    @(negedge clk); #2 rst = 0;
    @(posedge clk); #1;
    en = 2'b11; s0_vld = 1; s1_vld = 1; ack_mode[0] = 1; ack_mode[1] = 1;
    step();
    chk("t5_first_gnt", 32'(obs_srdy), 32'b01);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0)
        for (int n = 0; n < 2; n++)
          ack_mode[n] = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      s0_vld  = ($urandom_range(0, 3) != 0);
      s1_vld  = ($urandom_range(0, 3) != 0);
      s0_dat  = 16'($urandom);
      s1_dat  = 16'($urandom);
      en      = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      full    = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      err_clr = ($urandom_range(0, 31) == 0);
      step();
    end
    err_clr = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
